// File: rtl/seq_cla_subtractor_pkg.sv
// Shared definitions for the chunked carry-look-ahead subtractor:
// FSM state encoding and chunk/counter sizing helpers.
package seq_cla_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_CHUNK = 8;

  // Number of chunk passes for one operation; guards against a zero chunk size.
  function automatic int unsigned num_chunks(input int unsigned width, input int unsigned chunk);
    return (chunk == 0) ? 1 : width / chunk;
  endfunction

  // Chunk counter width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_cla_subtractor_cla_chunk.sv
// CHUNK-bit generate/propagate look-ahead adder, purely combinational.
module cla_chunk #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  logic [CHUNK-1:0] g;
  logic [CHUNK-1:0] p;
  logic [CHUNK:0]   c;

  assign g = x & y;
  assign p = x ^ y;

  // Every carry is a flat sum of products of g/p terms, not a ripple chain.
  always_comb begin : carry_tree
    logic c_term;
    logic prod;
    c      = '0;
    c_term = 1'b0;
    prod   = 1'b0;
    c[0]   = cin;
    for (int i = 0; i < int'(CHUNK); i++) begin
      c_term = g[i];
      prod   = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c_term = c_term | (g[j] & prod);
        prod   = prod & p[j];
      end
      c[i+1] = c_term | (cin & prod);
    end
  end

  assign s    = p ^ c[CHUNK-1:0];
  assign cout = c[CHUNK];

endmodule

// File: rtl/seq_cla_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, resolved CHUNK bits per cycle
// through a look-ahead chunk adder linked by a carry register.
module seq_cla_subtractor
  import seq_cla_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned NUM_CHUNKS = num_chunks(WIDTH, CHUNK);
  localparam int unsigned CW         = cnt_width(NUM_CHUNKS);

  generate
    if (CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : g_bad_param
      $error("seq_cla_subtractor: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  state_e           state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic [31:0]      idx;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] nb_chunk;
  logic [CHUNK-1:0] sum;
  logic             cout;
  logic             last;

  // Subtraction as a + ~b + ~bin, one chunk per cycle, LSB chunk first.
  assign idx      = 32'(cnt) * CHUNK;
  assign a_chunk  = a_q[idx +: CHUNK];
  assign nb_chunk = ~b_q[idx +: CHUNK];
  assign last     = (cnt == CW'(NUM_CHUNKS - 1));

  cla_chunk #(
    .CHUNK (CHUNK)
  ) u_cla_chunk (
    .x    (a_chunk),
    .y    (nb_chunk),
    .cin  (carry),
    .s    (sum),
    .cout (cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      carry     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      diff      <= '0;
      bout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= a;
            b_q      <= b;
            carry    <= ~bin;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          diff[idx +: CHUNK] <= sum;
          carry              <= cout;
          cnt                <= cnt + CW'(1);
          if (last) begin
            // Final carry of a + ~b + ~bin is the inverted borrow.
            cnt       <= '0;
            bout      <= ~cout;
            ovf       <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (sum[CHUNK-1] ^ a_q[WIDTH-1]);
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_cla_subtractor.sv
// Directed self-checking bench for seq_cla_subtractor at default parameters.
module tb_seq_cla_subtractor;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] diff;
  logic        bout;
  logic        ovf;

  int checks   = 0;
  int failures = 0;

  seq_cla_subtractor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction: accept, latency count, result check, optional stall, drain.
  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic bi, input logic [31:0] ed, input logic eb,
                        input logic eo, input int hold);
    int lat;
    a        = av;
    b        = bv;
    bin      = bi;
    in_valid = 1'b1;
    chk({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = ~av;
    b        = ~bv;
    bin      = ~bi;
    lat      = 99;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    chk({tag, ".latency"}, 32'(lat), 32'd4);
    chk({tag, ".diff"}, diff, ed);
    chk({tag, ".bout"}, 32'(bout), 32'(eb));
    chk({tag, ".ovf"}, 32'(ovf), 32'(eo));
    chk({tag, ".in_ready_done"}, 32'(in_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".hold_diff"}, diff, ed);
      chk({tag, ".hold_bout"}, 32'(bout), 32'(eb));
      chk({tag, ".hold_ovf"}, 32'(ovf), 32'(eo));
      chk({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".drain_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".drain_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, ".kept_diff"}, diff, ed);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.diff", diff, 32'h0);
    chk("reset.bout", 32'(bout), 32'd0);
    chk("reset.ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("basic",   32'h0000_0003, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 0);
    run_op("wrap",    32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 0);
    run_op("ovf_neg", 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 0);
    run_op("ovf_pos", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 0);
    run_op("bin_all", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 0);
    run_op("chunk",   32'h1234_5678, 32'h0234_5678, 1'b0, 32'h1000_0000, 1'b0, 1'b0, 0);
    run_op("bp",      32'h0000_0100, 32'h0000_0001, 1'b0, 32'h0000_00FF, 1'b0, 1'b0, 3);
    run_op("b2b",     32'h0000_0001, 32'h0000_0002, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0, 0);

    // Abort mid-RUN after two chunks have been processed.
    a        = 32'h5555_5555;
    b        = 32'h1111_1111;
    bin      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", 32'(out_valid), 32'd0);
    chk("midrst.diff", diff, 32'h0);
    chk("midrst.in_ready", 32'(in_ready), 32'd1);
    chk("midrst.bout", 32'(bout), 32'd0);
    chk("midrst.ovf", 32'(ovf), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst.no_result", 32'(out_valid), 32'd0);
    run_op("after_rst", 32'h0000_0010, 32'h0000_0008, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
